// File: rtl/al422_frame_writer.sv
// al422_frame_writer: write-side front end for the AL422 frame FIFO.
// Takes a byte stream over valid/ready and replays it onto the AL422 write
// port (WE, WRST, D) clocked by in_clk, which also serves as the AL422 WCK.
// Every frame opens with a write-pointer reset pulse and carries exactly
// FRAME_BYTES bytes. The byte contents are passed through unchanged.
module al422_frame_writer #(
  parameter int FRAME_BYTES = 9216,  // 1..393216
  parameter int WRST_CYCLES = 4,     // 1..15
  parameter int CNT_W       = 19     // 2**CNT_W > FRAME_BYTES
) (
  input  logic             in_clk,
  input  logic             in_nrst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [7:0]       al422_data_out,
  output logic             al422_we_out,
  output logic             al422_wrst_out,
  output logic [CNT_W-1:0] wr_count,
  output logic             frame_done,
  output logic             frame_err
);

  typedef enum logic [2:0] {
    IDLE,     // waiting for a start-of-frame byte
    WRST,     // holding the AL422 write pointer in reset
    RECOVER,  // one quiet cycle between WRST release and the first write
    FIRST,    // writing the byte captured with sof
    WRITE     // streaming the remaining bytes of the frame
  } state_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_BYTES);
  localparam logic [3:0]       WRST_LOAD  = 4'(WRST_CYCLES - 1);

  state_t           state;
  logic [7:0]       hold_q;     // sof byte parked while WRST runs
  logic [3:0]       wrst_cnt;   // remaining WRST-low cycles after this one
  logic             xfer;
  logic [CNT_W-1:0] count_inc;

  // in_ready is a register, so a transfer is decided purely by the source.
  assign xfer      = in_valid & in_ready;
  assign count_inc = wr_count + CNT_W'(1);

  // Frame sequencer. All outputs are registered here, next to the state.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      al422_data_out <= 8'h00;
      al422_we_out   <= 1'b1;
      al422_wrst_out <= 1'b1;
      wr_count       <= '0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
      hold_q         <= 8'h00;
      wrst_cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this
      // block override these defaults for the current cycle only.
      frame_done   <= 1'b0;
      al422_we_out <= 1'b1;

      if (xfer && in_sof) begin
        // in_ready is only high in IDLE, FIRST and WRITE, so an sof
        // anywhere but IDLE abandons a partial frame.
        if (state != IDLE) frame_err <= 1'b1;
        hold_q         <= in_data;
        wr_count       <= '0;
        in_ready       <= 1'b0;
        al422_wrst_out <= 1'b0;
        wrst_cnt       <= WRST_LOAD;
        state          <= WRST;
      end else begin
        case (state)
          IDLE: begin
            in_ready <= 1'b1;
            if (xfer) frame_err <= 1'b1;  // data byte outside any frame
          end

          WRST: begin
            if (wrst_cnt == '0) begin
              al422_wrst_out <= 1'b1;
              state          <= RECOVER;
            end else begin
              wrst_cnt <= wrst_cnt - 4'd1;
            end
          end

          RECOVER: begin
            al422_we_out   <= 1'b0;
            al422_data_out <= hold_q;
            wr_count       <= count_inc;
            state          <= FIRST;
            if (count_inc == LAST_COUNT) begin
              frame_done <= 1'b1;  // single-byte frame completes here
              in_ready   <= 1'b0;
            end else begin
              in_ready <= 1'b1;
            end
          end

          FIRST, WRITE: begin
            if (wr_count == LAST_COUNT) begin
              // Only reachable from FIRST on a single-byte frame.
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= WRITE;
              if (xfer) begin
                al422_we_out   <= 1'b0;
                al422_data_out <= in_data;
                wr_count       <= count_inc;
                if (count_inc == LAST_COUNT) begin
                  frame_done <= 1'b1;
                  in_ready   <= 1'b0;
                  state      <= IDLE;
                end
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_al422_frame_writer.sv
// Bench for al422_frame_writer: a cycle table for the reference frame, then
// frame-level sequences checked against a byte-stream model of the AL422
// write side, and a second instance configured for single-byte frames.
module tb_al422_frame_writer;

  localparam int FB = 9;
  localparam int W  = 4;
  localparam int CW = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_ready;
  logic [7:0]    dout;
  logic          we;
  logic          wrst;
  logic [CW-1:0] wr_count;
  logic          done;
  logic          err;

  logic [7:0]    d1_data = 8'h00;
  logic          d1_valid = 1'b0;
  logic          d1_sof = 1'b0;
  logic          d1_ready;
  logic [7:0]    d1_dout;
  logic          d1_we;
  logic          d1_wrst;
  logic [CW-1:0] d1_count;
  logic          d1_done;
  logic          d1_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  al422_frame_writer #(.FRAME_BYTES(FB), .WRST_CYCLES(W), .CNT_W(CW)) dut (
    .in_clk(clk), .in_nrst(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .al422_data_out(dout),
    .al422_we_out(we), .al422_wrst_out(wrst), .wr_count(wr_count),
    .frame_done(done), .frame_err(err)
  );

  al422_frame_writer #(.FRAME_BYTES(1), .WRST_CYCLES(W), .CNT_W(CW)) dut1 (
    .in_clk(clk), .in_nrst(rst_n), .in_data(d1_data), .in_valid(d1_valid),
    .in_sof(d1_sof), .in_ready(d1_ready), .al422_data_out(d1_dout),
    .al422_we_out(d1_we), .al422_wrst_out(d1_wrst), .wr_count(d1_count),
    .frame_done(d1_done), .frame_err(d1_err)
  );

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------- observed AL422 activity
  typedef struct { logic [7:0] data; int cnt; int cyc; } wr_t;
  typedef struct { int cnt; int cyc; } done_t;
  typedef struct { int start; int len; } run_t;

  wr_t   obs_wr[$],   exp_wr[$];
  done_t obs_done[$], exp_done[$];
  run_t  obs_run[$],  exp_run[$];
  int    run_len = 0;
  int    run_start = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else begin
      if (!we)   obs_wr.push_back('{dout, int'(wr_count), cyc});
      if (done)  obs_done.push_back('{int'(wr_count), cyc});
      if (!wrst) begin
        if (run_len == 0) run_start = cyc;
        run_len++;
      end else if (run_len > 0) begin
        obs_run.push_back('{run_start, run_len});
        run_len = 0;
      end
    end
  end

  // ------------------------------------------------------ reference model
  // Frame-level view: every accepted byte either opens a frame (sof), extends
  // the open frame, or is an error. A sof byte lands on the AL422 after the
  // WRST pulse and one recovery cycle; any other byte lands one cycle after
  // it is accepted.
  bit m_err;
  bit m_in_frame;
  int m_count;

  task automatic model_reset();
    m_err = 1'b0; m_in_frame = 1'b0; m_count = 0;
    exp_wr.delete(); exp_done.delete(); exp_run.delete();
    obs_wr.delete(); obs_done.delete(); obs_run.delete();
  endtask

  task automatic model_accept(input logic [7:0] d, input logic s, input int acc);
    if (s) begin
      if (m_in_frame) m_err = 1'b1;
      exp_run.push_back('{acc, W});
      m_count = 1;
      exp_wr.push_back('{d, 1, acc + W + 1});
      if (m_count == FB) begin
        exp_done.push_back('{FB, acc + W + 1});
        m_in_frame = 1'b0;
      end else begin
        m_in_frame = 1'b1;
      end
    end else if (m_in_frame) begin
      m_count++;
      exp_wr.push_back('{d, m_count, acc});
      if (m_count == FB) begin
        exp_done.push_back('{FB, acc});
        m_in_frame = 1'b0;
      end
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic compare_logs(input string name);
    check({name, "_wr_n"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      check({name, "_wr"},
            64'({obs_wr[i].data, 24'(obs_wr[i].cnt), 32'(obs_wr[i].cyc)}),
            64'({exp_wr[i].data, 24'(exp_wr[i].cnt), 32'(exp_wr[i].cyc)}));
    check({name, "_done_n"}, 64'(obs_done.size()), 64'(exp_done.size()));
    for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++)
      check({name, "_done"}, 64'({obs_done[i].cnt, obs_done[i].cyc}),
            64'({exp_done[i].cnt, exp_done[i].cyc}));
    check({name, "_wrst_n"}, 64'(obs_run.size()), 64'(exp_run.size()));
    for (int i = 0; i < obs_run.size() && i < exp_run.size(); i++)
      check({name, "_wrst"}, 64'({obs_run[i].start, obs_run[i].len}),
            64'({exp_run[i].start, exp_run[i].len}));
    obs_wr.delete(); obs_done.delete(); obs_run.delete();
    exp_wr.delete(); exp_done.delete(); exp_run.delete();
  endtask

  task automatic check_state(input string name);
    check({name, "_err"},   64'(err), 64'(m_err));
    check({name, "_count"}, 64'(wr_count), 64'(m_count));
  endtask

  // --------------------------------------------------------------- driving
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one byte and hold it until accepted (bounded wait).
  task automatic put(input logic [7:0] d, input logic s);
    int tries = 0;
    in_data = d; in_sof = s; in_valid = 1'b1;
    while (!in_ready && tries < 64) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      model_accept(d, s, cyc + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sof = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------- cycle table
  typedef struct {
    logic v; logic s; logic [7:0] d;                       // inputs
    logic rdy; logic we; logic wrst; logic [7:0] dout;     // expected
    int cnt; logic done;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic s, input logic [7:0] d,
                              input logic rdy, input logic w, input logic r,
                              input logic [7:0] o, input int c, input logic dn);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.rdy = rdy; t.we = w; t.wrst = r;
    t.dout = o; t.cnt = c; t.done = dn;
    return t;
  endfunction

  vec_t tbl[16];
  logic [7:0] frame_a[9];

  initial begin
    logic [7:0] r;
    int n;
    int aborts;

    //                v  s  d      rdy we wrst dout  cnt done
    tbl[0]  = mk(1, 1, 8'h2F, 1, 1, 1, 8'h00, 0, 0);
    tbl[1]  = mk(1, 0, 8'h03, 0, 1, 0, 8'h00, 0, 0);
    tbl[2]  = mk(1, 0, 8'h03, 0, 1, 0, 8'h00, 0, 0);
    tbl[3]  = mk(1, 0, 8'h03, 0, 1, 0, 8'h00, 0, 0);
    tbl[4]  = mk(1, 0, 8'h03, 0, 1, 0, 8'h00, 0, 0);
    tbl[5]  = mk(1, 0, 8'h03, 0, 1, 1, 8'h00, 0, 0);
    tbl[6]  = mk(1, 0, 8'h03, 1, 0, 1, 8'h2F, 1, 0);
    tbl[7]  = mk(1, 0, 8'h00, 1, 0, 1, 8'h03, 2, 0);
    tbl[8]  = mk(1, 0, 8'h05, 1, 0, 1, 8'h00, 3, 0);
    tbl[9]  = mk(1, 0, 8'h00, 1, 0, 1, 8'h05, 4, 0);
    tbl[10] = mk(1, 0, 8'h31, 1, 0, 1, 8'h00, 5, 0);
    tbl[11] = mk(1, 0, 8'h32, 1, 0, 1, 8'h31, 6, 0);
    tbl[12] = mk(1, 0, 8'h33, 1, 0, 1, 8'h32, 7, 0);
    tbl[13] = mk(1, 0, 8'h74, 1, 0, 1, 8'h33, 8, 0);
    tbl[14] = mk(0, 0, 8'h00, 0, 0, 1, 8'h74, 9, 1);
    tbl[15] = mk(0, 0, 8'h00, 1, 1, 1, 8'h74, 9, 0);
    frame_a = '{8'h2F, 8'h03, 8'h00, 8'h05, 8'h00, 8'h31, 8'h32, 8'h33, 8'h74};

    model_reset();

    // Reset values while in_nrst is low.
    #12;
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_we",    64'(we),       64'd1);
    check("rst_wrst",  64'(wrst),     64'd1);
    check("rst_data",  64'(dout),     64'd0);
    check("rst_count", 64'(wr_count), 64'd0);
    check("rst_flags", 64'({done, err}), 64'd0);
    check("rst_dut1",  64'({d1_ready, d1_we, d1_wrst, d1_dout, d1_count, d1_done, d1_err}),
          64'({1'b0, 1'b1, 1'b1, 8'h00, 19'd0, 1'b0, 1'b0}));
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference frame, valid every cycle, cycle by cycle.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tbl%0d", i),
            64'({in_ready, we, wrst, dout, 32'(wr_count), done}),
            64'({tbl[i].rdy, tbl[i].we, tbl[i].wrst, tbl[i].dout, tbl[i].cnt, tbl[i].done}));
      in_valid = tbl[i].v; in_sof = tbl[i].s; in_data = tbl[i].d;
      @(posedge clk); #1;
    end
    check("t1_err", 64'(err), 64'd0);
    obs_wr.delete(); obs_done.delete(); obs_run.delete();

    // Same frame with valid toggling 1-0-1-0.
    for (int i = 0; i < 9; i++) begin
      put(frame_a[i], i == 0);
      idle(1);
    end
    idle(3);
    compare_logs("t2");
    check_state("t2");

    // Data bytes with no frame open.
    do_reset();
    put(8'h11, 1'b0);
    put(8'h22, 1'b0);
    idle(3);
    compare_logs("t3");
    check_state("t3");

    // Abort: sof in the middle of a frame restarts WRST with the new byte.
    do_reset();
    put(8'h01, 1'b1);
    for (int i = 2; i <= 4; i++) put(8'(i), 1'b0);
    idle(3);
    check_state("t4a");
    put(8'hAA, 1'b1);
    for (int i = 0; i < 8; i++) put(8'(8'hB0 + i), 1'b0);
    idle(3);
    compare_logs("t4");
    check_state("t4b");

    // Reset asserted after five bytes have been written.
    do_reset();
    put(8'h40, 1'b1);
    for (int i = 1; i < 5; i++) put(8'(8'h40 + i), 1'b0);
    check("t5_we_low", 64'({we, 32'(wr_count)}), 64'({1'b0, 32'd5}));
    #5;
    rst_n = 1'b0;
    #1;
    check("t5_async_strobes", 64'({we, wrst}), 64'(2'b11));
    check("t5_async_ready",   64'(in_ready),   64'd0);
    check("t5_async_count",   64'(wr_count),   64'd0);
    compare_logs("t5a");
    do_reset();
    for (int i = 0; i < FB; i++) put(8'($urandom), i == 0);
    idle(3);
    compare_logs("t5b");
    check_state("t5b");

    // Random frames: random data and gaps, stray bytes, occasional abort.
    for (int f = 0; f < 6; f++) begin
      if ($urandom % 3 == 0) begin
        put(8'($urandom), 1'b0);
        idle($urandom_range(0, 2));
      end
      put(8'($urandom), 1'b1);
      n = 1;
      aborts = 0;
      while (n < FB) begin
        r = 8'($urandom);
        if (aborts < 1 && $urandom % 10 == 0) begin
          put(r, 1'b1);
          n = 1;
          aborts++;
        end else begin
          put(r, 1'b0);
          n++;
        end
        idle($urandom_range(0, 2));
      end
    end
    idle(3);
    compare_logs("rnd");
    check_state("rnd");

    // Single-byte frames on the second instance.
    check("f1_ready", 64'(d1_ready), 64'd1);
    d1_data = 8'h5A; d1_sof = 1'b1; d1_valid = 1'b1;
    @(posedge clk); #1;
    d1_valid = 1'b0; d1_sof = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("f1_wrst%0d", i), 64'({d1_wrst, d1_we, d1_ready}), 64'(3'b010));
      @(posedge clk); #1;
    end
    check("f1_recover", 64'({d1_wrst, d1_we, d1_ready}), 64'(3'b110));
    @(posedge clk); #1;
    check("f1_write", 64'({d1_we, d1_dout, 32'(d1_count), d1_done, d1_ready}),
          64'({1'b0, 8'h5A, 32'd1, 1'b1, 1'b0}));
    @(posedge clk); #1;
    check("f1_idle", 64'({d1_we, d1_wrst, d1_done, d1_ready, 32'(d1_count), d1_err}),
          64'({1'b1, 1'b1, 1'b0, 1'b1, 32'd1, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
